// File: rtl/instr_mem_pkg.sv
// Shared constants and address helpers for the synchronous instruction memory.
package instr_mem_pkg;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Addresses are widened to 64 bits so one helper serves any ADDR_W.
   function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input bit byte_addr);
      return byte_addr ? (addr >> 2) : addr;
   endfunction

   // True when the address selects a stored word and is word-aligned.
   function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth,
                                    input bit byte_addr);
      logic in_range;
      logic misaligned;
      in_range   = addr_to_idx(addr, byte_addr) < 64'(depth);
      misaligned = byte_addr && (addr[1:0] != 2'b00);
      return in_range && !misaligned;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Word storage with a synchronous write port and a synchronous read-first read port.
module instr_mem_array #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 128,
   parameter int unsigned IDX_W     = 7,
   parameter string       INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write and read on the same edge; the read samples the old word (read-first).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: one-cycle registered fetch with valid/error flags,
// stall/flush handling and a runtime program-load write port.
module instr_mem_sync
   import instr_mem_pkg::*;
#(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 128,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       BYTE_ADDR = 1,
   parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_WORD_DEFAULT),
   parameter string             INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic              err_sticky,
   input  logic              err_clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int unsigned SHIFT = (BYTE_ADDR != 0) ? 2 : 0;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // The address space must be able to reach every stored word.
   if ($clog2(DEPTH) > int'(ADDR_W) - int'(SHIFT)) begin : g_depth_chk
      $error("instr_mem_sync: DEPTH exceeds the addressable word range");
   end

   logic [63:0]       rd_addr_ext;
   logic [63:0]       wr_addr_ext;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic              rd_ok;
   logic              wr_ok;
   logic              fetch_go;
   logic              fetch_bad;
   logic              arr_rd_en;
   logic              arr_wr_en;
   logic [DATA_W-1:0] arr_rd_data;

   logic nop_sel_q;
   logic valid_q;
   logic err_q;
   logic sticky_q;

   // Address decode and fetch qualification.
   always_comb begin
      rd_addr_ext = 64'(rd_addr);
      wr_addr_ext = 64'(wr_addr);
      rd_idx      = IDX_W'(addr_to_idx(rd_addr_ext, BYTE_ADDR != 0));
      wr_idx      = IDX_W'(addr_to_idx(wr_addr_ext, BYTE_ADDR != 0));
      rd_ok       = addr_ok(rd_addr_ext, DEPTH, BYTE_ADDR != 0);
      wr_ok       = addr_ok(wr_addr_ext, DEPTH, BYTE_ADDR != 0);
      fetch_go    = rd_en && !stall && !flush;
      arr_rd_en   = fetch_go && rd_ok;
      fetch_bad   = fetch_go && !rd_ok;
      arr_wr_en   = wr_en && wr_ok;
   end

   // The array's read register only loads on good fetches, so it naturally holds
   // across stall and idle; nop_sel_q substitutes NOP_WORD after reset/flush/error.
   instr_mem_array #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_en   (arr_rd_en),
      .rd_idx  (rd_idx),
      .rd_data (arr_rd_data)
   );

   // Output control with priority flush > stall > fetch > idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nop_sel_q <= 1'b1;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else if (flush) begin
         nop_sel_q <= 1'b1;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else if (stall) begin
         nop_sel_q <= nop_sel_q;
         valid_q   <= valid_q;
         err_q     <= err_q;
      end else if (rd_en) begin
         nop_sel_q <= !rd_ok;
         valid_q   <= 1'b1;
         err_q     <= !rd_ok;
      end else begin
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end
   end

   // Sticky error: a new errored fetch wins over a same-edge clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else if (fetch_bad) begin
         sticky_q <= 1'b1;
      end else if (err_clr) begin
         sticky_q <= 1'b0;
      end
   end

   assign rd_data    = nop_sel_q ? NOP_WORD : arr_rd_data;
   assign rd_valid   = valid_q;
   assign rd_err     = err_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// word-array reference model; a second instance covers word addressing.
module tb_instr_mem_sync;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en, stall, flush, err_clr, wr_en;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [31:0] rd_data;
   logic        rd_valid, rd_err, err_sticky;

   logic        w_rd_en, w_wr_en;
   logic [31:0] w_rd_addr, w_wr_addr;
   logic [15:0] w_wr_data, w_rd_data;
   logic        w_rd_valid, w_rd_err, w_err_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_mem [128];
   logic [31:0] m_data;
   logic        m_valid, m_err, m_sticky;

   always #5 clk = ~clk;

   instr_mem_sync dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .stall(stall),
      .flush(flush), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .err_sticky(err_sticky), .err_clr(err_clr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   instr_mem_sync #(.DATA_W(16), .DEPTH(16), .BYTE_ADDR(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .rd_en(w_rd_en), .rd_addr(w_rd_addr), .stall(1'b0),
      .flush(1'b0), .rd_data(w_rd_data), .rd_valid(w_rd_valid), .rd_err(w_rd_err),
      .err_sticky(w_err_sticky), .err_clr(1'b0), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
      .wr_data(w_wr_data)
   );

   function automatic bit addr_good(input logic [31:0] a);
      return (a % 4 == 0) && (a / 4 < 128);
   endfunction

   task automatic model_reset();
      m_data = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
   endtask

   // Apply one clock edge of the specified behaviour using the current inputs.
   task automatic model_edge();
      bit bad_fetch;
      bad_fetch = 1'b0;
      if (flush) begin
         m_valid = 1'b0; m_err = 1'b0; m_data = 32'h0;
      end else if (stall) begin
         // everything holds
      end else if (rd_en) begin
         m_valid = 1'b1;
         if (addr_good(rd_addr)) begin
            m_data = m_mem[rd_addr / 4]; m_err = 1'b0;
         end else begin
            m_data = 32'h0; m_err = 1'b1; bad_fetch = 1'b1;
         end
      end else begin
         m_valid = 1'b0; m_err = 1'b0;
      end
      if (bad_fetch) m_sticky = 1'b1;
      else if (err_clr) m_sticky = 1'b0;
      if (wr_en && addr_good(wr_addr)) m_mem[wr_addr / 4] = wr_data;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      rd_en = 0; stall = 0; flush = 0; err_clr = 0; wr_en = 0;
      rd_addr = 0; wr_addr = 0; wr_data = 0;
      w_rd_en = 0; w_wr_en = 0; w_rd_addr = 0; w_wr_addr = 0; w_wr_data = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #3;
      n_checks++;
      if ({rd_valid, rd_err, err_sticky, rd_data} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b e=%b s=%b d=%h, want 0/0/0/00000000",
                  rd_valid, rd_err, err_sticky, rd_data);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_preload();
      for (int i = 0; i < 128; i++) begin
         wr_en = 1; wr_addr = i * 4; wr_data = $urandom;
         if (i == 0) wr_data = 32'h0023_00AA;
         if (i == 1) wr_data = 32'h1065_4321;
         if (i == 2) wr_data = 32'h0010_0022;
         if (i == 3) wr_data = 32'h1122_3344;
         tick();
      end
      wr_en = 0;
   endtask

   task automatic test_fetch();
      rd_en = 1; rd_addr = 0;
      tick();
      n_checks++;
      if (rd_data !== 32'h0023_00AA || rd_valid !== 1'b1 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_w0: got d=%h v=%b e=%b, want 002300aa/1/0", rd_data, rd_valid, rd_err);
      end
      rd_addr = 4;
      tick();
      n_checks++;
      if (rd_data !== 32'h1065_4321 || rd_valid !== 1'b1 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_w1: got d=%h v=%b e=%b, want 10654321/1/0", rd_data, rd_valid, rd_err);
      end
      rd_en = 0;
      tick();
      n_checks++;
      if (rd_data !== 32'h1065_4321 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got d=%h v=%b, want 10654321/0", rd_data, rd_valid);
      end
   endtask

   task automatic test_errors();
      logic [31:0] bad [2];
      bad[0] = 32'h202;
      bad[1] = 32'h200;
      for (int i = 0; i < 2; i++) begin
         rd_en = 1; rd_addr = bad[i];
         tick();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== 32'h0 || err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_addr_%0d: got v=%b e=%b d=%h s=%b, want 1/1/00000000/1",
                     i, rd_valid, rd_err, rd_data, err_sticky);
         end
      end
      rd_en = 0; err_clr = 1;
      tick();
      err_clr = 0;
      n_checks++;
      if (err_sticky !== 1'b0 || rd_err !== 1'b0 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: got s=%b e=%b v=%b, want 0/0/0", err_sticky, rd_err, rd_valid);
      end
      // Clear and new error on the same edge: set wins.
      rd_en = 1; rd_addr = 32'h3; err_clr = 1;
      tick();
      rd_en = 0; err_clr = 0;
      n_checks++;
      if (err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clr: got s=%b, want 1", err_sticky);
      end
      err_clr = 1;
      tick();
      err_clr = 0;
   endtask

   task automatic test_stall();
      rd_en = 1; rd_addr = 8;
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rd_addr = 32'h10 + i * 4;
         tick();
         n_checks++;
         if (rd_data !== 32'h0010_0022 || rd_valid !== 1'b1 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got d=%h v=%b e=%b, want 00100022/1/0",
                     i, rd_data, rd_valid, rd_err);
         end
      end
      stall = 0; rd_en = 0;
   endtask

   task automatic test_flush_rdw();
      rd_en = 1; rd_addr = 8;
      tick();
      stall = 1; flush = 1;
      tick();
      stall = 0; flush = 0;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h0 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_prio: got v=%b d=%h e=%b, want 0/00000000/0", rd_valid, rd_data, rd_err);
      end
      rd_addr = 12; wr_en = 1; wr_addr = 12; wr_data = 32'hAC65_4321;
      tick();
      wr_en = 0;
      n_checks++;
      if (rd_data !== 32'h1122_3344 || rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL read_first_old: got d=%h v=%b, want 11223344/1", rd_data, rd_valid);
      end
      tick();
      rd_en = 0;
      n_checks++;
      if (rd_data !== 32'hAC65_4321) begin
         n_fail++;
         $display("FAIL read_first_new: got d=%h, want ac654321", rd_data);
      end
   endtask

   task automatic test_async_reset();
      rd_en = 1; rd_addr = 32'h201;
      tick();
      rd_addr = 4;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({rd_valid, rd_err, err_sticky, rd_data} !== 35'h0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b e=%b s=%b d=%h, want 0/0/0/00000000",
                  rd_valid, rd_err, err_sticky, rd_data);
      end
      #2;
      rst_n = 1'b1;
      tick();
      rd_en = 0;
      n_checks++;
      if (rd_data !== 32'h1065_4321 || rd_valid !== 1'b1 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_fetch: got d=%h v=%b e=%b, want 10654321/1/0",
                  rd_data, rd_valid, rd_err);
      end
   endtask

   task automatic test_word_mode();
      w_wr_en = 1; w_wr_addr = 15; w_wr_data = 16'hBEEF;
      tick();
      w_wr_addr = 3; w_wr_data = 16'h1234;
      tick();
      w_wr_addr = 16; w_wr_data = 16'hDEAD;
      tick();
      w_wr_en = 0; w_rd_en = 1; w_rd_addr = 15;
      tick();
      n_checks++;
      if (w_rd_data !== 16'hBEEF || w_rd_valid !== 1'b1 || w_rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL word_idx15: got d=%h v=%b e=%b, want beef/1/0", w_rd_data, w_rd_valid, w_rd_err);
      end
      w_rd_addr = 3;
      tick();
      n_checks++;
      if (w_rd_data !== 16'h1234 || w_rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL word_idx3: got d=%h e=%b, want 1234/0", w_rd_data, w_rd_err);
      end
      w_rd_addr = 16;
      tick();
      w_rd_en = 0;
      n_checks++;
      if (w_rd_err !== 1'b1 || w_rd_valid !== 1'b1 || w_rd_data !== 16'h0 || w_err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL word_idx16: got e=%b v=%b d=%h s=%b, want 1/1/0000/1",
                  w_rd_err, w_rd_valid, w_rd_data, w_err_sticky);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r <= 5) return $urandom_range(0, 127) * 4;
      if (r == 6) return $urandom_range(0, 127) * 4 + $urandom_range(1, 3);
      return 32'h200 + $urandom_range(0, 4095);
   endfunction

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rd_en   = ($urandom_range(0, 3) != 0);
         rd_addr = rand_addr();
         stall   = ($urandom_range(0, 4) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         err_clr = ($urandom_range(0, 5) == 0);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = rand_addr();
         wr_data = $urandom;
         tick();
         n_checks++;
         if ({rd_valid, rd_err, err_sticky, rd_data} !== {m_valid, m_err, m_sticky, m_data}) begin
            n_fail++;
            $display("FAIL random_%0d: got v=%b e=%b s=%b d=%h, want v=%b e=%b s=%b d=%h",
                     i, rd_valid, rd_err, err_sticky, rd_data, m_valid, m_err, m_sticky, m_data);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_preload();
      test_fetch();
      test_errors();
      test_stall();
      test_flush_rdw();
      test_async_reset();
      test_word_mode();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want finish before 200000");
      $fatal(1);
   end

endmodule
